inf_prefetch: RTL and testbench
===============================

# inf_prefetch

Parametrised instruction-fetch prefetch buffer, next generation of the front-end fetch stage. Sits between the I-cache line port and the decoder. Fetches aligned cache lines into a circular byte buffer, discards responses made stale by a redirect, and presents a sliding window of instruction bytes plus its RIP to the decoder. Line size, buffer depth and window width are parameters.

## Interface
- LINE_BYTES, 64, cache line size in bytes; power of two.
- BUF_LINES, 2, buffer depth in lines; BUF_BYTES = LINE_BYTES*BUF_LINES; power of two.
- WINDOW, 15, decode window width in bytes; WINDOW ≤ LINE_BYTES.
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- set_rip  in  1  redirect strobe.
- new_rip  in  64  redirect target, valid with set_rip.
- ic_enable  out  1  line request valid; held until ic_done.
- iaddr  out  64  line address, always LINE_BYTES-aligned; held with ic_enable.
- idata  in  LINE_BYTES*8  line data; byte i at bits [i*8+:8].
- ic_done  in  1  response strobe; only meaningful while ic_enable=1.
- decode_bytes  out  WINDOW*8  window; byte i at bits [i*8+:8], i=0 at decode_rip.
- decode_rip  out  64  address of window byte 0.
- if_dc  out  1  window valid: occupancy ≥ WINDOW.
- dc_if  in  1  decoder consuming this cycle.
- bytes_decoded  in  8  bytes consumed; sampled only when dc_if && if_dc.
- occupancy  out  $clog2(BUF_BYTES)+1  valid bytes in buffer.

## Operation
- State machine: IDLE, WAIT (request outstanding), DRAIN (request outstanding, response to be discarded). Plus `running` flag, cleared by reset, set by first set_rip.
- Reset: state IDLE, running=0, ic_enable=0, iaddr=0, decode_rip=0, occupancy=0, rd/wr pointers=0, fetch_skip=0, if_dc=0, decode_bytes=0.
- Redirect (set_rip=1), highest priority: decode_rip<=new_rip; fetch_rip<=new_rip aligned down; fetch_skip<=new_rip mod LINE_BYTES; occupancy, rd, wr <=0; running<=1. Consume is ignored that cycle. WAIT→DRAIN unless ic_done same cycle (then →IDLE, data discarded). DRAIN stays DRAIN.
- Issue (IDLE, running, no set_rip, issue condition true): ic_enable<=1, iaddr<=fetch_rip, →WAIT.
- Fill (WAIT, ic_done): bytes fetch_skip..LINE_BYTES-1 written at wr, wrapping mod BUF_BYTES; wr and occupancy += LINE_BYTES-fetch_skip; fetch_skip<=0; fetch_rip+=LINE_BYTES; ic_enable<=0; →IDLE.
- Drain (DRAIN, ic_done): idata dropped, ic_enable<=0, →IDLE; next issue uses redirected fetch_rip.
- Consume (dc_if && if_dc, no set_rip): rd+=bytes_decoded mod BUF_BYTES; decode_rip+=bytes_decoded; occupancy-=bytes_decoded.
- Simultaneous fill and consume: occupancy <= occupancy + filled − consumed in one update.
- decode_bytes byte i = buffer[(rd+i) mod BUF_BYTES] for i < occupancy, else 0.
- Protocol errors (simulation assertion, $error): bytes_decoded > WINDOW; ic_done in IDLE.
- Arithmetic: pointers $clog2(BUF_BYTES) bits, natural wrap; fetch_rip/decode_rip 64-bit, wrap at 2^64.

## Timing
- set_rip at edge T → ic_enable=1, iaddr=aligned new_rip visible after edge T+1.
- ic_done at edge E → occupancy/if_dc updated after E; next ic_enable earliest after E+1.
- Consume at edge C → decode_bytes/decode_rip for new window valid after C; back-to-back consumes each cycle supported.
- One request outstanding at most; ic_enable never drops without ic_done except on reset.
- Redirect during WAIT costs the remaining latency of the stale request plus one cycle.

## Configuration
- INF_PREFETCH_EN defined: issue condition = BUF_BYTES − occupancy ≥ LINE_BYTES (run-ahead prefetch, keeps buffer full).
- Not defined: issue condition = occupancy < WINDOW and BUF_BYTES − occupancy ≥ LINE_BYTES (demand fetch only).

## Test plan
- reset_n=0 two cycles, then set_rip new_rip=0x1000 → ic_enable=1, iaddr=0x1000 after T+1; ic_done → occupancy=64, if_dc=1, decode_bytes = idata bytes 0..14.
- set_rip new_rip=0x1023 → iaddr=0x1000; after fill occupancy=29, decode_rip=0x1023, byte 0 = idata byte 0x23.
- With INF_PREFETCH_EN, BUF_LINES=2: consume 15/cycle → second request 0x1040 issued right after first fill; window straddling rd wrap (rd=120) returns correct contiguous bytes.
- set_rip 0x2000 while WAIT on 0x1000 → DRAIN; ic_done with junk → discarded, occupancy=0, then iaddr=0x2000.
- Same-cycle ic_done and dc_if with bytes_decoded=7 at occupancy=20, skip=0 → occupancy=77.
- reset_n=0 during WAIT → ic_enable=0, occupancy=0, no request until next set_rip.

Source files
------------

// File: rtl/inf_prefetch.sv
// Instruction-fetch prefetch buffer: fetches aligned lines into a circular byte buffer and presents a decode window.
// Define INF_PREFETCH_EN for run-ahead prefetch; otherwise lines are fetched only when the window runs short.
module inf_prefetch #(
  parameter int LINE_BYTES = 64,
  parameter int BUF_LINES  = 2,
  parameter int WINDOW     = 15
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         set_rip,
  input  logic [63:0]                                  new_rip,
  output logic                                         ic_enable,
  output logic [63:0]                                  iaddr,
  input  logic [LINE_BYTES*8-1:0]                      idata,
  input  logic                                         ic_done,
  output logic [WINDOW*8-1:0]                          decode_bytes,
  output logic [63:0]                                  decode_rip,
  output logic                                         if_dc,
  input  logic                                         dc_if,
  input  logic [7:0]                                   bytes_decoded,
  output logic [$clog2(LINE_BYTES*BUF_LINES):0]        occupancy
);

  // state   | meaning
  // S_IDLE  | no request outstanding
  // S_WAIT  | request outstanding, response will be written to the buffer
  // S_DRAIN | request outstanding, response is stale and will be dropped

  localparam int BUF_BYTES = LINE_BYTES * BUF_LINES;
  localparam int PW        = $clog2(BUF_BYTES);
  localparam int OW        = PW + 1;
  localparam int SW        = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t          r_state;
  logic            r_running;
  logic [63:0]     r_fetch_rip;
  logic [SW-1:0]   r_skip;
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [OW-1:0]   r_occ;
  logic [7:0]      r_buf [BUF_BYTES];

  logic            w_consume;
  logic            w_fill;
  logic            w_issue;
  logic [OW-1:0]   w_fill_len;
  logic [OW-1:0]   w_room;

  assign w_consume  = dc_if && if_dc && !set_rip;
  assign w_fill     = reset_n && (r_state == S_WAIT) && ic_done && !set_rip;
  assign w_fill_len = OW'(LINE_BYTES) - OW'(r_skip);
  assign w_room     = OW'(BUF_BYTES) - r_occ;

`ifdef INF_PREFETCH_EN
  assign w_issue = (w_room >= OW'(LINE_BYTES));
`else
  assign w_issue = (r_occ < OW'(WINDOW)) && (w_room >= OW'(LINE_BYTES));
`endif

  assign occupancy = r_occ;
  assign if_dc     = (r_occ >= OW'(WINDOW));

  // Leading bytes of a redirected line (below the target offset) are never stored.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      for (int j = 0; j < LINE_BYTES; j++) begin
        if (j >= int'(r_skip)) begin
          r_buf[PW'(int'(r_wr) + j - int'(r_skip))] <= idata[j*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_running   <= 1'b0;
      r_fetch_rip <= '0;
      r_skip      <= '0;
      r_rd        <= '0;
      r_wr        <= '0;
      r_occ       <= '0;
      ic_enable   <= 1'b0;
      iaddr       <= '0;
      decode_rip  <= '0;
    end else if (set_rip) begin
      decode_rip  <= new_rip;
      r_fetch_rip <= new_rip & ~(64'(LINE_BYTES) - 64'd1);
      r_skip      <= new_rip[SW-1:0];
      r_rd        <= '0;
      r_wr        <= '0;
      r_occ       <= '0;
      r_running   <= 1'b1;
      if (r_state != S_IDLE) begin
        if (ic_done) begin
          r_state   <= S_IDLE;
          ic_enable <= 1'b0;
        end else begin
          r_state   <= S_DRAIN;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_running && w_issue) begin
            ic_enable <= 1'b1;
            iaddr     <= r_fetch_rip;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ic_done) begin
            r_wr        <= r_wr + PW'(w_fill_len);
            r_skip      <= '0;
            r_fetch_rip <= r_fetch_rip + 64'(LINE_BYTES);
            ic_enable   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (ic_done) begin
            ic_enable <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          ic_enable <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
      if (w_consume) begin
        r_rd       <= r_rd + PW'(bytes_decoded);
        decode_rip <= decode_rip + 64'(bytes_decoded);
      end
      r_occ <= r_occ + (w_fill ? w_fill_len : '0) - (w_consume ? OW'(bytes_decoded) : '0);
    end
  end

  always_comb begin
    decode_bytes = '0;
    for (int i = 0; i < WINDOW; i++) begin
      if (OW'(i) < r_occ) begin
        decode_bytes[i*8 +: 8] = r_buf[r_rd + PW'(i)];
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (dc_if && if_dc) begin
        assert (bytes_decoded <= 8'(WINDOW))
          else $error("inf_prefetch: bytes_decoded %0d exceeds window", bytes_decoded);
      end
      assert (!(ic_done && (r_state == S_IDLE)))
        else $error("inf_prefetch: ic_done with no request outstanding");
    end
  end

endmodule

// File: tb/tb_inf_prefetch.sv
// Testbench for inf_prefetch: byte-queue reference model compared every cycle, plus hand-computed checkpoints.
module tb_inf_prefetch;

  localparam int LB  = 64;
  localparam int BL  = 2;
  localparam int WIN = 15;
  localparam int BB  = LB * BL;
  localparam int OW  = $clog2(BB) + 1;

  logic              clk;
  logic              reset_n;
  logic              set_rip;
  logic [63:0]       new_rip;
  logic              ic_enable;
  logic [63:0]       iaddr;
  logic [LB*8-1:0]   idata;
  logic              ic_done;
  logic [WIN*8-1:0]  decode_bytes;
  logic [63:0]       decode_rip;
  logic              if_dc;
  logic              dc_if;
  logic [7:0]        bytes_decoded;
  logic [OW-1:0]     occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  inf_prefetch #(.LINE_BYTES(LB), .BUF_LINES(BL), .WINDOW(WIN)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .set_rip       (set_rip),
    .new_rip       (new_rip),
    .ic_enable     (ic_enable),
    .iaddr         (iaddr),
    .idata         (idata),
    .ic_done       (ic_done),
    .decode_bytes  (decode_bytes),
    .decode_rip    (decode_rip),
    .if_dc         (if_dc),
    .dc_if         (dc_if),
    .bytes_decoded (bytes_decoded),
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Deterministic line contents keyed by address, so every byte is traceable.
  function automatic logic [LB*8-1:0] line_data(input logic [63:0] a);
    logic [LB*8-1:0] d;
    logic [7:0]      base;
    base = 8'(int'(a[13:6]) * 37);
    for (int i = 0; i < LB; i++) d[i*8 +: 8] = base + 8'(3 * i) + 8'd1;
    return d;
  endfunction

  function automatic logic [LB*8-1:0] junk_data();
    logic [LB*8-1:0] d;
    for (int i = 0; i < LB; i++) d[i*8 +: 8] = 8'hE0 ^ 8'(i);
    return d;
  endfunction

  // ---------------- reference model: buffer as a byte queue ----------------
  bit          m_valid = 0;
  int          m_phase;          // 0 no request, 1 live request, 2 stale request
  bit          m_running;
  bit          m_ic_en;
  logic [63:0] m_iaddr;
  logic [63:0] m_fetch;
  int          m_skip;
  logic [63:0] m_drip;
  logic [7:0]  m_q[$];

  function automatic bit issue_ok(input int occ);
`ifdef INF_PREFETCH_EN
    return (BB - occ) >= LB;
`else
    return (occ < WIN) && ((BB - occ) >= LB);
`endif
  endfunction

  always @(posedge clk) begin
    bit cons;
    if (!reset_n) begin
      m_valid = 1; m_phase = 0; m_running = 0; m_ic_en = 0; m_iaddr = '0;
      m_fetch = '0; m_skip = 0; m_drip = '0; m_q.delete();
    end else if (m_valid) begin
      cons = dc_if && (m_q.size() >= WIN) && !set_rip;
      if (set_rip) begin
        m_drip    = new_rip;
        m_fetch   = (new_rip / LB) * LB;
        m_skip    = int'(new_rip % LB);
        m_q.delete();
        m_running = 1;
        if (m_phase != 0) begin
          if (ic_done) begin m_phase = 0; m_ic_en = 0; end
          else m_phase = 2;
        end
      end else begin
        if (m_phase == 0) begin
          if (m_running && issue_ok(m_q.size())) begin
            m_ic_en = 1; m_iaddr = m_fetch; m_phase = 1;
          end
        end else if (ic_done) begin
          if (m_phase == 1) begin
            for (int j = m_skip; j < LB; j++) m_q.push_back(idata[j*8 +: 8]);
            m_fetch = m_fetch + LB;
            m_skip  = 0;
          end
          m_ic_en = 0; m_phase = 0;
        end
        if (cons) begin
          for (int k = 0; k < int'(bytes_decoded); k++) void'(m_q.pop_front());
          m_drip = m_drip + 64'(bytes_decoded);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [WIN*8-1:0] exp_win;
    if (m_valid) begin
      exp_win = '0;
      for (int i = 0; i < WIN; i++) if (i < m_q.size()) exp_win[i*8 +: 8] = m_q[i];
      check("m_ic_enable",    128'(ic_enable),    128'(m_ic_en));
      check("m_iaddr",        128'(iaddr),        128'(m_iaddr));
      check("m_decode_rip",   128'(decode_rip),   128'(m_drip));
      check("m_occupancy",    128'(occupancy),    128'(m_q.size()));
      check("m_if_dc",        128'(if_dc),        128'(m_q.size() >= WIN));
      check("m_decode_bytes", 128'(decode_bytes), 128'(exp_win));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [63:0] a);
    set_rip = 1'b1; new_rip = a;
    tick();
    set_rip = 1'b0;
  endtask

  task automatic consume(input int n);
    dc_if = 1'b1; bytes_decoded = 8'(n);
    tick();
    dc_if = 1'b0; bytes_decoded = '0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 50 && !ic_enable; k++) tick();
    check("req_issued", 128'(ic_enable), 128'(1));
  endtask

  task automatic respond(input int lat, input bit junk);
    for (int k = 0; k < lat; k++) tick();
    if (ic_enable) begin
      idata   = junk ? junk_data() : line_data(iaddr);
      ic_done = 1'b1;
      tick();
      ic_done = 1'b0;
    end else begin
      check("respond_no_request", 128'(ic_enable), 128'(1));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; set_rip = 1'b0; new_rip = '0; idata = '0; ic_done = 1'b0;
    dc_if = 1'b0; bytes_decoded = '0;
    tick(); tick();
    check("rst_ic_enable", 128'(ic_enable), 128'(0));
    check("rst_iaddr",     128'(iaddr),     128'(0));
    check("rst_occupancy", 128'(occupancy), 128'(0));
    check("rst_if_dc",     128'(if_dc),     128'(0));
    check("rst_drip",      128'(decode_rip), 128'(0));
    check("rst_window",    128'(decode_bytes), 128'(0));
    reset_n = 1'b1;
    tick(); tick();
    check("idle_no_run", 128'(ic_enable), 128'(0));

    redirect(64'h1000);
    check("redir_T_no_req", 128'(ic_enable), 128'(0));
    tick();
    check("redir_T1_req",   128'(ic_enable), 128'(1));
    check("redir_T1_iaddr", 128'(iaddr),     128'(64'h1000));
    respond(2, 1'b0);
    check("fill_occ",   128'(occupancy), 128'(64));
    check("fill_if_dc", 128'(if_dc),     128'(1));
    check("fill_b0",    128'(decode_bytes[7:0]),     128'(8'h41));
    check("fill_b14",   128'(decode_bytes[119:112]), 128'(8'h6B));

`ifndef INF_PREFETCH_EN
    tick();
    check("demand_no_issue", 128'(ic_enable), 128'(0));
    consume(15); consume(15); consume(14);
    check("occ_20", 128'(occupancy), 128'(20));
    consume(7);
    check("occ_13",      128'(occupancy),  128'(13));
    check("drip_1033",   128'(decode_rip), 128'(64'h1033));
    check("short_b0",    128'(decode_bytes[7:0]),     128'(8'hDA));
    check("short_tail0", 128'(decode_bytes[119:104]), 128'(0));
    wait_req();
    check("second_iaddr", 128'(iaddr), 128'(64'h1040));
    respond(0, 1'b0);
    check("occ_77",   128'(occupancy), 128'(77));
    check("seam_b13", 128'(decode_bytes[111:104]), 128'(8'h66));
    for (int k = 0; k < 4; k++) consume(15);
    consume(7);
    wait_req();
    check("third_iaddr", 128'(iaddr), 128'(64'h1080));
    respond(1, 1'b0);
    check("wrap_occ", 128'(occupancy), 128'(74));
    check("wrap_b9",  128'(decode_bytes[79:72]), 128'(8'h23));
    check("wrap_b10", 128'(decode_bytes[87:80]), 128'(8'h8B));

    redirect(64'h1023);
    tick();
    check("skip_iaddr", 128'(iaddr), 128'(64'h1000));
    respond(1, 1'b0);
    check("skip_occ",  128'(occupancy),  128'(29));
    check("skip_drip", 128'(decode_rip), 128'(64'h1023));
    check("skip_b0",   128'(decode_bytes[7:0]), 128'(8'hAA));

    consume(15);
    wait_req();
    redirect(64'h2000);
    check("drain_hold_req",   128'(ic_enable), 128'(1));
    check("drain_hold_iaddr", 128'(iaddr),     128'(64'h1040));
    check("drain_occ0",       128'(occupancy), 128'(0));
    respond(1, 1'b1);
    check("drained_occ0",  128'(occupancy), 128'(0));
    check("drained_no_req", 128'(ic_enable), 128'(0));
    wait_req();
    check("redir_iaddr", 128'(iaddr), 128'(64'h2000));
    respond(0, 1'b0);
    check("redir_b0", 128'(decode_bytes[7:0]), 128'(8'h81));

    consume(15); consume(15); consume(15); consume(5);
    wait_req();
    set_rip = 1'b1; new_rip = 64'h3005; idata = junk_data(); ic_done = 1'b1;
    tick();
    set_rip = 1'b0; ic_done = 1'b0;
    check("redir_done_req",  128'(ic_enable),  128'(0));
    check("redir_done_occ",  128'(occupancy),  128'(0));
    check("redir_done_drip", 128'(decode_rip), 128'(64'h3005));
    wait_req();
    check("redir3_iaddr", 128'(iaddr), 128'(64'h3000));
    respond(0, 1'b0);
    check("redir3_occ", 128'(occupancy), 128'(59));
    check("redir3_b0",  128'(decode_bytes[7:0]), 128'(8'hD0));

    consume(15); consume(15); consume(15);
    wait_req();
`else
    tick();
    check("pf_second_req",   128'(ic_enable), 128'(1));
    check("pf_second_iaddr", 128'(iaddr),     128'(64'h1040));
    consume(15); consume(15); consume(14);
    check("pf_occ_20", 128'(occupancy), 128'(20));
    dc_if = 1'b1; bytes_decoded = 8'd7; idata = line_data(iaddr); ic_done = 1'b1;
    tick();
    dc_if = 1'b0; bytes_decoded = '0; ic_done = 1'b0;
    check("pf_occ_77", 128'(occupancy), 128'(77));
    for (int k = 0; k < 12; k++) begin
      consume(15);
      if (ic_enable) respond(0, 1'b0);
    end
    redirect(64'h5000);
    wait_req();
`endif

    reset_n = 1'b0;
    tick();
    check("rst_wait_req",   128'(ic_enable), 128'(0));
    check("rst_wait_occ",   128'(occupancy), 128'(0));
    check("rst_wait_iaddr", 128'(iaddr),     128'(0));
    reset_n = 1'b1;
    tick(); tick(); tick();
    check("rst_no_req", 128'(ic_enable), 128'(0));
    redirect(64'h4000);
    wait_req();
    check("post_rst_iaddr", 128'(iaddr), 128'(64'h4000));
    respond(0, 1'b0);
    check("post_rst_occ", 128'(occupancy), 128'(64));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
